// File: rtl/bsg_sipo_packet_arbiter.sv
// Packet-granular round-robin arbiter that steers one of several serial
// channels into a shared SIPO assembler and reports the owning channel.
module bsg_sipo_packet_arbiter #(
  parameter int width_p    = 8,
  parameter int els_p      = 4,
  parameter int num_chan_p = 3,
  parameter int lg_chan_lp = (num_chan_p > 1) ? $clog2(num_chan_p) : 1,
  parameter int lg_els_lp  = (els_p > 1) ? $clog2(els_p) : 1
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,
  input  logic [num_chan_p-1:0]         v_i,
  input  logic [num_chan_p*width_p-1:0] data_i,
  output logic [num_chan_p-1:0]         ready_and_o,
  output logic                          sipo_v_o,
  output logic [width_p-1:0]            sipo_data_o,
  input  logic                          sipo_ready_and_i,
  output logic [lg_chan_lp-1:0]         chan_o,
  output logic                          chan_v_o
);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e                r_state;
  logic [lg_chan_lp-1:0] r_grant;
  logic [lg_chan_lp-1:0] r_rr_ptr;
  logic [lg_els_lp-1:0]  r_beat;

  logic [width_p-1:0]    w_data [num_chan_p];
  logic [num_chan_p-1:0] w_sel;
  logic                  w_sel_v;
  logic [width_p-1:0]    w_sel_data;
  logic                  w_busy;
  logic                  w_hs;
  logic                  w_last;
  logic [lg_chan_lp-1:0] w_next_ptr;
  logic [lg_chan_lp-1:0] w_pick_hi;
  logic [lg_chan_lp-1:0] w_pick_lo;
  logic                  w_found_hi;
  logic [lg_chan_lp-1:0] w_pick;

  assign w_busy = (r_state == BUSY);

  genvar gi;
  generate
    for (gi = 0; gi < num_chan_p; gi++) begin : g_chan
      assign w_data[gi]      = data_i[gi*width_p +: width_p];
      assign w_sel[gi]       = (r_grant == lg_chan_lp'(gi));
      assign ready_and_o[gi] = w_busy & w_sel[gi] & sipo_ready_and_i;
    end
  endgenerate

  always_comb begin
    w_sel_v    = 1'b0;
    w_sel_data = '0;
    for (int k = 0; k < num_chan_p; k++) begin
      if (w_sel[k]) begin
        w_sel_v    = v_i[k];
        w_sel_data = w_data[k];
      end
    end
  end

  // Round-robin pick: lowest requester at or above the pointer, else lowest overall.
  always_comb begin
    w_pick_hi  = '0;
    w_pick_lo  = '0;
    w_found_hi = 1'b0;
    for (int k = num_chan_p - 1; k >= 0; k--) begin
      if (v_i[k]) begin
        w_pick_lo = lg_chan_lp'(k);
        if (lg_chan_lp'(k) >= r_rr_ptr) begin
          w_pick_hi  = lg_chan_lp'(k);
          w_found_hi = 1'b1;
        end
      end
    end
  end

  assign w_pick     = w_found_hi ? w_pick_hi : w_pick_lo;
  assign w_next_ptr = (r_grant == lg_chan_lp'(num_chan_p - 1)) ? '0 : r_grant + 1'b1;

  assign sipo_v_o    = w_busy & w_sel_v;
  assign sipo_data_o = w_sel_data;
  assign w_hs        = sipo_v_o & sipo_ready_and_i;
  assign w_last      = (r_beat == lg_els_lp'(els_p - 1));
  assign chan_o      = r_grant;
  assign chan_v_o    = w_busy;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state  <= IDLE;
      r_grant  <= '0;
      r_rr_ptr <= '0;
      r_beat   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|v_i) begin
            r_grant <= w_pick;
            r_state <= BUSY;
          end
        end
        BUSY: begin
          if (w_hs) begin
            if (w_last) begin
              r_beat   <= '0;
              r_rr_ptr <= w_next_ptr;
              r_state  <= IDLE;
            end else begin
              r_beat <= r_beat + 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bsg_sipo_packet_arbiter.sv
// Bench for bsg_sipo_packet_arbiter: per-channel word sources, a scoreboard of
// expected (channel, word) handshakes, a vector table and corner-case sequences.
module tb_bsg_sipo_packet_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  v_i;
  logic [23:0] data_i;
  logic [2:0]  ready_and_o;
  logic        sipo_v_o;
  logic [7:0]  sipo_data_o;
  logic        sipo_ready;
  logic [1:0]  chan_o;
  logic        chan_v_o;

  logic        v1;
  logic [7:0]  data1;
  logic        ready1;
  logic        sipo_v1;
  logic [7:0]  sipo_data1;
  logic        sipo_ready1;
  logic        chan1;
  logic        chan_v1;

  always #5 clk = ~clk;

  bsg_sipo_packet_arbiter #(.width_p(8), .els_p(4), .num_chan_p(3)) dut (
    .clk_i(clk), .reset_n_i(reset_n), .v_i(v_i), .data_i(data_i),
    .ready_and_o(ready_and_o), .sipo_v_o(sipo_v_o), .sipo_data_o(sipo_data_o),
    .sipo_ready_and_i(sipo_ready), .chan_o(chan_o), .chan_v_o(chan_v_o)
  );

  bsg_sipo_packet_arbiter #(.width_p(8), .els_p(1), .num_chan_p(1)) dut1 (
    .clk_i(clk), .reset_n_i(reset_n), .v_i(v1), .data_i(data1),
    .ready_and_o(ready1), .sipo_v_o(sipo_v1), .sipo_data_o(sipo_data1),
    .sipo_ready_and_i(sipo_ready1), .chan_o(chan1), .chan_v_o(chan_v1)
  );

  typedef struct {
    int         chan;
    logic [7:0] data;
  } exp_t;

  typedef struct {
    logic       rdy;
    logic [2:0] ready;
    logic       sv;
    logic       cv;
    logic [1:0] chan;
    logic [7:0] data;
  } vec_t;

  exp_t       exp_q[$];
  logic [7:0] src_q[3][$];
  logic [2:0] src_en;
  vec_t       tbl[6];

  int n_checks = 0;
  int n_err    = 0;
  int last_cycles;

  logic [2:0] s_ready;
  logic       s_sv, s_cv, s_hs1, s_chan1;
  logic [1:0] s_chan;
  logic [7:0] s_data;

  always @(negedge clk)
    if (reset_n) assert ($onehot0(ready_and_o)) else $error("ready_and_o not onehot0");

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic drive();
    for (int c = 0; c < 3; c++) begin
      if (src_en[c] && src_q[c].size() > 0) begin
        v_i[c]            = 1'b1;
        data_i[c*8 +: 8]  = src_q[c][0];
      end else begin
        v_i[c]            = 1'b0;
        data_i[c*8 +: 8]  = 8'h00;
      end
    end
  endtask

  task automatic load_pkt(input int c, input logic [7:0] base);
    for (int w = 0; w < 4; w++) begin
      src_q[c].push_back(base + 8'(w));
      exp_q.push_back('{c, base + 8'(w)});
    end
  endtask

  // One clock: sample at negedge, score handshakes, advance sources after posedge.
  task automatic cycle();
    logic [2:0] hs;
    exp_t e;
    @(negedge clk);
    s_ready = ready_and_o; s_sv = sipo_v_o; s_cv = chan_v_o;
    s_chan  = chan_o;      s_data = sipo_data_o;
    s_hs1   = sipo_v1 & sipo_ready1; s_chan1 = chan1;
    chk("onehot0", 32'($onehot0(ready_and_o)), 1);
    if (sipo_v_o && sipo_ready) begin
      $display("xfer chan=%0d data=%02h", chan_o, sipo_data_o);
      if (exp_q.size() == 0) begin
        n_checks++; n_err++;
        $display("FAIL sb_unexpected: got chan %0d data %02h expected no transfer", chan_o, sipo_data_o);
      end else begin
        e = exp_q.pop_front();
        chk("sb_chan", chan_o, e.chan);
        chk("sb_data", sipo_data_o, e.data);
        chk("sb_chan_v", chan_v_o, 1);
      end
    end
    hs = ready_and_o & v_i;
    @(posedge clk);
    #1;
    for (int c = 0; c < 3; c++) if (hs[c]) void'(src_q[c].pop_front());
    drive();
  endtask

  task automatic run_until_empty(input int bound);
    last_cycles = 0;
    while (exp_q.size() > 0 && last_cycles < bound) begin
      cycle();
      last_cycles++;
    end
    chk("drain_left", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    exp_q.delete();
    for (int c = 0; c < 3; c++) src_q[c].delete();
    src_en = 3'b000;
    sipo_ready = 1'b1;
    drive();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{1'b1, 3'b000, 1'b0, 1'b0, 2'd0, 8'd0};
    tbl[1] = '{1'b1, 3'b010, 1'b1, 1'b1, 2'd1, 8'd11};
    tbl[2] = '{1'b1, 3'b010, 1'b1, 1'b1, 2'd1, 8'd12};
    tbl[3] = '{1'b1, 3'b010, 1'b1, 1'b1, 2'd1, 8'd13};
    tbl[4] = '{1'b1, 3'b010, 1'b1, 1'b1, 2'd1, 8'd14};
    tbl[5] = '{1'b1, 3'b000, 1'b0, 1'b0, 2'd0, 8'd0};

    v1 = 1'b1; data1 = 8'hA5; sipo_ready1 = 1'b1;
    src_en = 3'b000; sipo_ready = 1'b1;
    drive();

    // Reset state while held in reset
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", ready_and_o, 0);
    chk("rst_sipo_v", sipo_v_o, 0);
    chk("rst_chan_v", chan_v_o, 0);
    chk("rst_chan", chan_o, 0);
    chk("rst_sipo_v1", sipo_v1, 0);

    // Test 1: channel 1 alone, table-driven
    do_reset();
    load_pkt(1, 8'd11);
    src_en = 3'b010;
    drive();
    for (int i = 0; i < 6; i++) begin
      sipo_ready = tbl[i].rdy;
      cycle();
      chk("t1_ready", s_ready, tbl[i].ready);
      chk("t1_sipo_v", s_sv, tbl[i].sv);
      chk("t1_chan_v", s_cv, tbl[i].cv);
      if (tbl[i].cv) chk("t1_chan", s_chan, tbl[i].chan);
      if (tbl[i].sv) chk("t1_data", s_data, tbl[i].data);
    end
    chk("t1_left", exp_q.size(), 0);

    // Test 2: all channels busy -> order 0,1,2,0, one idle cycle per packet
    do_reset();
    load_pkt(0, 8'h20);
    load_pkt(1, 8'h30);
    load_pkt(2, 8'h40);
    load_pkt(0, 8'h24);
    src_en = 3'b111;
    drive();
    run_until_empty(60);
    chk("t2_cycles", last_cycles, 20);

    // Test 3: granted channel 2 bubbles; channel 0 must wait
    do_reset();
    load_pkt(2, 8'h50);
    load_pkt(0, 8'h58);
    src_en = 3'b100;
    drive();
    cycle();
    src_en = 3'b101;
    drive();
    cycle();
    cycle();
    src_en = 3'b001;
    drive();
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("t3_ready", s_ready, 3'b100);
      chk("t3_sipo_v", s_sv, 0);
      chk("t3_chan_v", s_cv, 1);
      chk("t3_chan", s_chan, 2);
    end
    src_en = 3'b101;
    drive();
    run_until_empty(40);

    // Test 4: assembler stalls on the last word
    do_reset();
    load_pkt(1, 8'h60);
    src_en = 3'b010;
    drive();
    repeat (4) cycle();
    sipo_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("t4_sipo_v", s_sv, 1);
      chk("t4_chan_v", s_cv, 1);
      chk("t4_chan", s_chan, 1);
      chk("t4_ready", s_ready, 0);
      chk("t4_beat", dut.r_beat, 3);
    end
    chk("t4_pending", exp_q.size(), 1);
    sipo_ready = 1'b1;
    cycle();
    cycle();
    chk("t4_idle_chan_v", s_cv, 0);
    chk("t4_left", exp_q.size(), 0);

    // Test 5: asynchronous reset mid-packet, then a fresh packet from ch0
    do_reset();
    load_pkt(1, 8'h70);
    src_en = 3'b010;
    drive();
    cycle();
    cycle();
    chk("t5_busy", chan_v_o, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("t5_ready", ready_and_o, 0);
    chk("t5_sipo_v", sipo_v_o, 0);
    chk("t5_chan_v", chan_v_o, 0);
    chk("t5_chan", chan_o, 0);
    chk("t5_beat", dut.r_beat, 0);
    reset_n = 1'b1;
    exp_q.delete();
    for (int c = 0; c < 3; c++) src_q[c].delete();
    load_pkt(0, 8'h80);
    load_pkt(1, 8'h90);
    src_en = 3'b011;
    drive();
    run_until_empty(40);

    // Test 6: els_p=1, num_chan_p=1 -> handshake every other cycle
    do_reset();
    for (int k = 0; k < 10; k++) begin
      cycle();
      chk("t6_hs", s_hs1, (k % 2) == 1);
      chk("t6_chan", s_chan1, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
